// File: rtl/fm_op_sequencer.sv
// Time-multiplexes one shared FM operator datapath across NUM_SLOTS slots per
// audio sample, owns the per-slot register file and phase accumulators.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for sample_tick; mix accumulators cleared on start
// S_ISSUE  | latch slot phase/waveform/atten onto op_*, pulse op_start
// S_WAIT   | hold op_* until the datapath returns op_done
// S_ACCUM  | mix result into L/R, advance or reset the slot phase
// S_OUTPUT | saturate mix into audio_l/audio_r, pulse sample_valid
module fm_op_sequencer #(
  parameter  int NUM_SLOTS = 8,
  localparam int SW        = $clog2(NUM_SLOTS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          sample_tick_i,
  input  logic [SW+1:0] bus_addr_i,
  input  logic          bus_wren_i,
  input  logic [15:0]   bus_wrdata_i,
  output logic [15:0]   bus_rddata_o,
  output logic          op_start_o,
  output logic [9:0]    op_phase_o,
  output logic [2:0]    op_waveform_o,
  output logic [11:0]   op_atten_o,
  input  logic          op_done_i,
  input  logic [12:0]   op_result_i,
  output logic [15:0]   audio_l_o,
  output logic [15:0]   audio_r_o,
  output logic          sample_valid_o,
  output logic          overrun_o
);

  localparam int MW = 13 + SW;
  localparam logic signed [MW+2:0] SAT_MAX = (MW+3)'(32767);
  localparam logic signed [MW+2:0] SAT_MIN = (MW+3)'(-32768);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_OUTPUT} state_t;

  logic [9:0]           fnum_q  [NUM_SLOTS];
  logic [2:0]           block_q [NUM_SLOTS];
  logic [3:0]           mult_q  [NUM_SLOTS];
  logic [2:0]           wave_q  [NUM_SLOTS];
  logic [11:0]          atten_q [NUM_SLOTS];
  logic [18:0]          phase_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] kon_q, pan_l_q, pan_r_q, prst_q;

  state_t               state_q;
  logic [SW-1:0]        slot_q;
  logic signed [MW-1:0] mix_l_q, mix_r_q;
  logic [12:0]          result_q;
  logic [15:0]          rddata_q, audio_l_q, audio_r_q;
  logic                 op_start_q, sample_valid_q, overrun_q;
  logic [9:0]           op_phase_q;
  logic [2:0]           op_wave_q;
  logic [11:0]          op_atten_q;

  logic [SW-1:0]        wr_slot;
  logic [1:0]           wr_reg;
  logic [15:0]          rddata_d;
  logic [15:0]          base16;
  logic [4:0]           cur_mf;
  logic [18:0]          inc;
  logic [18:0]          phase_d;
  logic signed [MW-1:0] res_ext, mix_l_d, mix_r_d;
  logic                 unused_wrdata;

  function automatic logic [4:0] mult_factor(input logic [3:0] m);
    case (m)
      4'd0:    mult_factor = 5'd1;
      4'd1:    mult_factor = 5'd2;
      4'd2:    mult_factor = 5'd4;
      4'd3:    mult_factor = 5'd6;
      4'd4:    mult_factor = 5'd8;
      4'd5:    mult_factor = 5'd10;
      4'd6:    mult_factor = 5'd12;
      4'd7:    mult_factor = 5'd14;
      4'd8:    mult_factor = 5'd16;
      4'd9:    mult_factor = 5'd18;
      4'd10:   mult_factor = 5'd20;
      4'd11:   mult_factor = 5'd20;
      4'd12:   mult_factor = 5'd24;
      4'd13:   mult_factor = 5'd24;
      default: mult_factor = 5'd30;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [MW-1:0] m);
    logic signed [MW+2:0] s;
    s = {m, 3'b000};
    if (s > SAT_MAX)      sat16 = 16'h7fff;
    else if (s < SAT_MIN) sat16 = 16'h8000;
    else                  sat16 = s[15:0];
  endfunction

  assign wr_slot       = bus_addr_i[SW+1:2];
  assign wr_reg        = bus_addr_i[1:0];
  assign unused_wrdata = ^bus_wrdata_i[15:14];

  always_comb begin
    rddata_d = '0;
    case (wr_reg)
      2'd0:    rddata_d = {2'b0, kon_q[wr_slot], block_q[wr_slot], fnum_q[wr_slot]};
      2'd1:    rddata_d = {7'b0, pan_r_q[wr_slot], pan_l_q[wr_slot], wave_q[wr_slot],
                           mult_q[wr_slot]};
      2'd2:    rddata_d = {4'b0, atten_q[wr_slot]};
      default: rddata_d = '0;
    endcase
  end

  // Increment and kon are taken from the live registers in the ACCUM cycle.
  always_comb begin
    base16  = {6'b0, fnum_q[slot_q]} << block_q[slot_q];
    cur_mf  = mult_factor(mult_q[slot_q]);
    inc     = 19'(base16) * 19'(cur_mf);
    phase_d = prst_q[slot_q] ? '0 : phase_q[slot_q] + inc;
    res_ext = {{SW{result_q[12]}}, result_q};
    mix_l_d = (kon_q[slot_q] && pan_l_q[slot_q]) ? mix_l_q + res_ext : mix_l_q;
    mix_r_d = (kon_q[slot_q] && pan_r_q[slot_q]) ? mix_r_q + res_ext : mix_r_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        fnum_q[i]  <= '0;
        block_q[i] <= '0;
        mult_q[i]  <= '0;
        wave_q[i]  <= '0;
        atten_q[i] <= '0;
        phase_q[i] <= '0;
      end
      kon_q          <= '0;
      pan_l_q        <= '0;
      pan_r_q        <= '0;
      prst_q         <= '0;
      state_q        <= S_IDLE;
      slot_q         <= '0;
      mix_l_q        <= '0;
      mix_r_q        <= '0;
      result_q       <= '0;
      rddata_q       <= '0;
      audio_l_q      <= '0;
      audio_r_q      <= '0;
      op_start_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      op_phase_q     <= '0;
      op_wave_q      <= '0;
      op_atten_q     <= '0;
    end else begin
      rddata_q       <= rddata_d;
      op_start_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      if (sample_tick_i && state_q != S_IDLE) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (sample_tick_i) begin
            slot_q  <= '0;
            mix_l_q <= '0;
            mix_r_q <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          op_phase_q <= phase_q[slot_q][18:9];
          op_wave_q  <= wave_q[slot_q];
          op_atten_q <= atten_q[slot_q];
          op_start_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (op_done_i) begin
            result_q <= op_result_i;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          mix_l_q         <= mix_l_d;
          mix_r_q         <= mix_r_d;
          phase_q[slot_q] <= phase_d;
          prst_q[slot_q]  <= 1'b0;
          if (slot_q == SW'(NUM_SLOTS-1)) begin
            state_q <= S_OUTPUT;
          end else begin
            slot_q  <= slot_q + 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_OUTPUT: begin
          audio_l_q      <= sat16(mix_l_q);
          audio_r_q      <= sat16(mix_r_q);
          sample_valid_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Placed after ACCUM so a kon rise in the same cycle keeps its flag.
      if (bus_wren_i) begin
        case (wr_reg)
          2'd0: begin
            fnum_q[wr_slot]  <= bus_wrdata_i[9:0];
            block_q[wr_slot] <= bus_wrdata_i[12:10];
            kon_q[wr_slot]   <= bus_wrdata_i[13];
            if (bus_wrdata_i[13] && !kon_q[wr_slot]) prst_q[wr_slot] <= 1'b1;
          end
          2'd1: begin
            mult_q[wr_slot]  <= bus_wrdata_i[3:0];
            wave_q[wr_slot]  <= bus_wrdata_i[6:4];
            pan_l_q[wr_slot] <= bus_wrdata_i[7];
            pan_r_q[wr_slot] <= bus_wrdata_i[8];
          end
          2'd2:    atten_q[wr_slot] <= bus_wrdata_i[11:0];
          default: ;
        endcase
      end
    end
  end

  assign bus_rddata_o   = rddata_q;
  assign op_start_o     = op_start_q;
  assign op_phase_o     = op_phase_q;
  assign op_waveform_o  = op_wave_q;
  assign op_atten_o     = op_atten_q;
  assign audio_l_o      = audio_l_q;
  assign audio_r_o      = audio_r_q;
  assign sample_valid_o = sample_valid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_fm_op_sequencer.sv
// Directed bench for fm_op_sequencer with a fixed-latency operator datapath model.
module tb_fm_op_sequencer;
  localparam int NS  = 8;
  localparam int SW  = 3;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic [SW+1:0] bus_addr = '0;
  logic          bus_wren = 1'b0;
  logic [15:0]   bus_wrdata = '0;
  logic [15:0]   bus_rddata;
  logic          op_start;
  logic [9:0]    op_phase;
  logic [2:0]    op_waveform;
  logic [11:0]   op_atten;
  logic          op_done;
  logic          op_done_m = 1'b0;
  logic          extra_done = 1'b0;
  logic [12:0]   op_result = '0;
  logic [15:0]   audio_l, audio_r;
  logic          sample_valid, overrun;

  logic               dp_en = 1'b1;
  logic signed [12:0] dp_val = '0;
  int                 dp_cnt = 0;
  int                 sv_cnt = 0;
  int                 st_cnt = 0;
  logic [9:0]         iss_q[$];
  int                 n_total = 0;
  int                 n_pass = 0;

  always #5 clk = ~clk;
  assign op_done = op_done_m | extra_done;

  fm_op_sequencer #(.NUM_SLOTS(NS)) dut (
    .clk_i(clk), .reset_i(reset), .sample_tick_i(sample_tick),
    .bus_addr_i(bus_addr), .bus_wren_i(bus_wren), .bus_wrdata_i(bus_wrdata),
    .bus_rddata_o(bus_rddata), .op_start_o(op_start), .op_phase_o(op_phase),
    .op_waveform_o(op_waveform), .op_atten_o(op_atten), .op_done_i(op_done),
    .op_result_i(op_result), .audio_l_o(audio_l), .audio_r_o(audio_r),
    .sample_valid_o(sample_valid), .overrun_o(overrun)
  );

  // Datapath model: answers each op_start with dp_val after LAT cycles.
  always @(posedge clk) begin
    op_done_m <= 1'b0;
    if (sample_valid) sv_cnt <= sv_cnt + 1;
    if (op_start) begin
      st_cnt <= st_cnt + 1;
      iss_q.push_back(op_phase);
    end
    if (reset) dp_cnt <= 0;
    else if (dp_cnt != 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) begin
        op_done_m <= 1'b1;
        op_result <= dp_val;
      end
    end else if (op_start && dp_en) dp_cnt <= LAT;
  end

  task automatic wr(input int slot, input int r, input logic [15:0] d);
    @(negedge clk);
    bus_addr = (SW+2)'(slot * 4 + r);
    bus_wrdata = d;
    bus_wren = 1'b1;
    @(negedge clk);
    bus_wren = 1'b0;
  endtask

  task automatic rd(input int slot, input int r, output logic [15:0] d);
    @(negedge clk);
    bus_addr = (SW+2)'(slot * 4 + r);
    @(negedge clk);
    d = bus_rddata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dp_en = 1'b1;
  endtask

  task automatic run_sample(input string nm);
    int base;
    int cyc;
    base = sv_cnt;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    cyc = 0;
    while (sv_cnt == base && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (sv_cnt == base) $display("FAIL %s_timeout: no sample_valid after %0d cycles", nm, cyc);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    do_reset();
    n_total++;
    if ({op_start, sample_valid, overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {op_start, sample_valid, overrun});
    else n_pass++;
    n_total++;
    if ({audio_l, audio_r} !== 32'h0)
      $display("FAIL reset_audio: got %h want 0", {audio_l, audio_r});
    else n_pass++;
    n_total++;
    if ({op_phase, op_waveform, op_atten} !== 25'h0)
      $display("FAIL reset_op: got %h want 0", {op_phase, op_waveform, op_atten});
    else n_pass++;
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < 4; r++) begin
        rd(s, r, d);
        n_total++;
        if (d !== 16'h0) $display("FAIL reset_reg s%0d r%0d: got %h want 0000", s, r, d);
        else n_pass++;
      end
  endtask

  task automatic test_regs();
    logic [15:0] d;
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'h3fff; exp_rd[1] = 16'h01ff; exp_rd[2] = 16'h0fff; exp_rd[3] = 16'h0000;
    for (int r = 0; r < 4; r++) wr(5, r, 16'hffff);
    for (int r = 0; r < 4; r++) begin
      rd(5, r, d);
      n_total++;
      if (d !== exp_rd[r]) $display("FAIL reg_mask r%0d: got %h want %h", r, d, exp_rd[r]);
      else n_pass++;
    end
    rd(4, 0, d);
    n_total++;
    if (d !== 16'h0) $display("FAIL reg_other_slot: got %h want 0000", d);
    else n_pass++;
  endtask

  task automatic test_phase();
    int exp_ph [3];
    exp_ph[0] = 0; exp_ph[1] = 3; exp_ph[2] = 6;
    do_reset();
    dp_val = 13'sd0;
    wr(0, 1, 16'h0008);
    wr(0, 0, 16'h2064);
    run_sample("phase_prime");
    for (int k = 0; k < 3; k++) begin
      iss_q.delete();
      run_sample("phase");
      n_total++;
      if (iss_q.size() != NS) $display("FAIL phase_issue_count k%0d: got %0d want %0d", k, iss_q.size(), NS);
      else n_pass++;
      if (iss_q.size() == NS) begin
        n_total++;
        if (int'(iss_q[0]) != exp_ph[k]) $display("FAIL phase_slot0 k%0d: got %0d want %0d", k, iss_q[0], exp_ph[k]);
        else n_pass++;
        for (int s = 1; s < NS; s++) begin
          n_total++;
          if (iss_q[s] !== 10'd0) $display("FAIL phase_other k%0d s%0d: got %0d want 0", k, s, iss_q[s]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [12:0] vals [4];
    logic [15:0]        exps [4];
    int                 base;
    vals[0] = 13'sd4095;  exps[0] = 16'h7fff;
    vals[1] = -13'sd4096; exps[1] = 16'h8000;
    vals[2] = 13'sd10;    exps[2] = 16'd640;
    vals[3] = -13'sd5;    exps[3] = 16'hfec0;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      wr(s, 0, 16'h2000);
      wr(s, 1, 16'h0180);
    end
    for (int k = 0; k < 4; k++) begin
      dp_val = vals[k];
      base = sv_cnt;
      run_sample("sat");
      repeat (20) @(negedge clk);
      n_total++;
      if (audio_l !== exps[k]) $display("FAIL sat_l k%0d: got %h want %h", k, audio_l, exps[k]);
      else n_pass++;
      n_total++;
      if (audio_r !== exps[k]) $display("FAIL sat_r k%0d: got %h want %h", k, audio_r, exps[k]);
      else n_pass++;
      n_total++;
      if (sv_cnt != base + 1) $display("FAIL sat_valid_count k%0d: got %0d want 1", k, sv_cnt - base);
      else n_pass++;
    end
  endtask

  task automatic test_pan();
    do_reset();
    wr(3, 0, 16'h2000);
    wr(3, 1, 16'h0080);
    dp_val = 13'sd100;
    run_sample("pan");
    n_total++;
    if (audio_l !== 16'd800) $display("FAIL pan_l: got %0d want 800", audio_l);
    else n_pass++;
    n_total++;
    if (audio_r !== 16'd0) $display("FAIL pan_r: got %0d want 0", audio_r);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (audio_l !== 16'd800) $display("FAIL pan_hold: got %0d want 800", audio_l);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    int base_sv;
    int base_st;
    dp_en = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      if (op_start) seen = 1;
      else @(negedge clk);
    end
    n_total++;
    if (seen == 0) $display("FAIL rstmid_issue: got no op_start want one");
    else n_pass++;
    @(negedge clk);
    base_sv = sv_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({op_start, sample_valid, overrun} !== 3'b000)
      $display("FAIL rstmid_flags: got %b want 000", {op_start, sample_valid, overrun});
    else n_pass++;
    n_total++;
    if ({audio_l, audio_r} !== 32'h0) $display("FAIL rstmid_audio: got %h want 0", {audio_l, audio_r});
    else n_pass++;
    base_st = st_cnt;
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    repeat (20) @(negedge clk);
    n_total++;
    if (st_cnt != base_st || sv_cnt != base_sv)
      $display("FAIL rstmid_idle: got starts %0d valids %0d want 0 0", st_cnt - base_st, sv_cnt - base_sv);
    else n_pass++;
    dp_en = 1'b1;
    run_sample("rstmid_recover");
  endtask

  task automatic test_overrun();
    int seen;
    int base;
    do_reset();
    wr(3, 0, 16'h2000);
    wr(3, 1, 16'h0080);
    dp_val = 13'sd100;
    base = sv_cnt;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && seen < 3; c++) begin
      @(negedge clk);
      if (op_start) seen++;
    end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int c = 0; c < 400 && sv_cnt == base; c++) @(negedge clk);
    repeat (80) @(negedge clk);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun);
    else n_pass++;
    n_total++;
    if (sv_cnt != base + 1) $display("FAIL overrun_valid_count: got %0d want 1", sv_cnt - base);
    else n_pass++;
    n_total++;
    if (audio_l !== 16'd800) $display("FAIL overrun_audio: got %0d want 800", audio_l);
    else n_pass++;
    run_sample("overrun_next");
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun);
    else n_pass++;
  endtask

  task automatic test_kon_reset();
    int exp_ph [3];
    exp_ph[0] = 6; exp_ph[1] = 0; exp_ph[2] = 3;
    do_reset();
    dp_val = 13'sd0;
    wr(0, 1, 16'h0008);
    wr(0, 0, 16'h2064);
    run_sample("kon_prime");
    run_sample("kon_adv1");
    run_sample("kon_adv2");
    wr(0, 0, 16'h0064);
    wr(0, 0, 16'h2064);
    for (int k = 0; k < 3; k++) begin
      iss_q.delete();
      run_sample("kon");
      n_total++;
      if (iss_q.size() == 0) $display("FAIL kon_phase k%0d: got no issue want %0d", k, exp_ph[k]);
      else if (int'(iss_q[0]) != exp_ph[k]) $display("FAIL kon_phase k%0d: got %0d want %0d", k, iss_q[0], exp_ph[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_phase();
    test_saturation();
    test_pan();
    test_reset_mid();
    test_overrun();
    test_kon_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fm_op_sequencer.md
Name: fm_op_sequencer

Overview:
Time-multiplexes one shared 3-stage FM operator datapath (logsin -> exp -> result) across NUM_SLOTS operator slots per audio sample. Holds the per-slot register file and the per-slot phase accumulators. Issues one operator evaluation per slot and mixes the signed results into stereo 16-bit samples. Sits between the CPU register bus, the operator datapath and the audio output path.

Parameters:
NUM_SLOTS, 8, operator slots per sample; power of two, 2..32
SW, $clog2(NUM_SLOTS), slot index width (derived; not overridable)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle strobe at audio sample rate
bus_addr  in  SW+2  {slot, reg[1:0]}
bus_wren  in  1  write strobe
bus_wrdata  in  16  write data
bus_rddata  out  16  read data, 1-cycle latency, always valid for the previous cycle's bus_addr
op_start  out  1  one-cycle pulse launching a datapath evaluation
op_phase  out  10  phase_acc[slot][18:9], held stable from op_start until op_done
op_waveform  out  3  slot waveform, held as op_phase
op_atten  out  12  slot attenuation, held as op_phase
op_done  in  1  datapath result valid strobe
op_result  in  13  signed two's-complement operator output
audio_l  out  16  left sample
audio_r  out  16  right sample
sample_valid  out  1  one-cycle pulse when audio_l/audio_r update
overrun  out  1  sticky: sample_tick arrived while busy; cleared only by reset

Behaviour:
- Registers per slot, selected by addr[1:0]:
  - 0: fnum[9:0], block[12:10], kon[13].
  - 1: mult[3:0], waveform[6:4], pan_l[7], pan_r[8].
  - 2: atten[11:0].
  - 3: reserved; writes are ignored, reads return 0.
- Unused bits read as 0.
- Writes take effect the cycle after bus_wren.
- Reset values:
  - Registers, phase accumulators, outputs, overrun and mix: all 0.
  - State: IDLE.
- Phase increment: inc = ((fnum << block)[15:0]) * M(mult), where M = 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
- phase_acc is 19 bits; it wraps modulo 2^19.
- A kon 0->1 write sets a per-slot phase-reset flag.
- FSM:
  - IDLE: on sample_tick, slot=0, mix_l=mix_r=0, go to ISSUE.
  - ISSUE: latch the slot's phase/waveform/atten into the op_* outputs. Pulse op_start for 1 cycle. Go to WAIT.
  - WAIT: hold until op_done. No timeout.
  - ACCUM:
    - If kon=1, add sign-extended op_result to mix_l if pan_l and to mix_r if pan_r.
    - Mix accumulators are 13+SW bits signed.
    - If the slot's reset flag is set: phase_acc=0 and clear the flag.
    - Otherwise phase_acc += inc, always advanced even when kon=0.
    - If slot==NUM_SLOTS-1 go to OUTPUT; else slot+1, go to ISSUE.
  - OUTPUT: audio_x = saturate(mix_x <<< 3) to [-32768, 32767]. Pulse sample_valid. Go to IDLE.
- Minimum period: NUM_SLOTS*(2+datapath latency)+2 cycles per sample.
- sample_tick outside IDLE: ignored and overrun set. A tick in the same cycle that OUTPUT returns to IDLE counts as an overrun.
- A register write to the in-flight slot between ISSUE and ACCUM:
  - op_* outputs stay latched.
  - inc and kon used in ACCUM are the values current in the ACCUM cycle.
- A kon rising write and ACCUM for that slot in the same cycle: the flag is set and applied at the next sample's ACCUM.
- audio_l/audio_r hold their value between sample_valid pulses.
- Reset mid-operation:
  - Abandons the sample; op_start is deasserted.
  - Any op_done arriving after reset is ignored (FSM in IDLE).

Test Plan:
- Reset, then read all registers -> 0. Outputs, overrun and sample_valid are 0.
- Slot0 fnum=100, block=0, mult=8, kon=1; apply 3 ticks with the datapath model -> op_phase per sample = 0, 3, 6 (inc=1600). Other slots issue op_phase=0.
- All 8 slots kon=1, pan_l=pan_r=1, model returns 4095 -> audio_l=audio_r=32767. Returns -4096 -> -32768. Exactly one sample_valid per tick.
- Slot3 pan_l=1, pan_r=0, result 100, others kon=0 -> audio_l=800, audio_r=0.
- Tick asserted during WAIT of slot 2 -> overrun=1 and stays 1. The current sample completes normally; no extra sample_valid.
- Slot0 advanced to phase_acc>0; write kon 1->0->1 -> next sample after that slot's ACCUM: op_phase=0. Also: reset asserted during WAIT -> IDLE, outputs 0, no sample_valid.
